// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, baud-rate table and parity modes.
// Also used by the matching transmitter.
package uart_pkg;

  localparam int CNT_W = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_CHECK,
    S_STOP
  } uart_state_t;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_ODD      = 2'b01,
    PAR_EVEN     = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_mode_t;

  function automatic int baud_rate(input logic [2:0] mode);
    case (mode)
      3'd1:    return 19200;
      3'd2:    return 38400;
      3'd3:    return 115200;
      3'd4:    return 230400;
      3'd5:    return 460800;
      3'd6:    return 921600;
      default: return 9600;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] bit_period(input int clk_freq, input logic [2:0] mode);
    return CNT_W'(clk_freq / baud_rate(mode));
  endfunction

endpackage

// File: rtl/uart_baud_div.sv
// Bit-timing down-counter: a restart loads the half period, after which the
// counter reloads with the full period every time it reaches zero.
module uart_baud_div
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       restart,
  input  logic [2:0] bps_mode,
  output logic       tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] period_tab [8];
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] cnt;

  // Loop bounds and CLK_FREQ are constant, so the whole table folds to constants.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      period_tab[i] = bit_period(CLK_FREQ, 3'(i));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      period_q <= '0;
      cnt      <= '0;
    end else if (restart) begin
      period_q <= period_tab[bps_mode];
      cnt      <= (period_tab[bps_mode] >> 1) - ONE;
    end else if (cnt == '0) begin
      cnt <= period_q - ONE;
    end else begin
      cnt <= cnt - ONE;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_recv.sv
// Configurable UART receiver: 1-16 data bits MSB first, optional parity,
// 1-4 stop bits, single-word holding register with overrun detection.
//
// state   | meaning
// IDLE    | waiting for a 1->0 edge on the armed, synchronized line
// START   | waiting half a bit to confirm the start bit
// DATA    | sampling data bits every bit period
// CHECK   | sampling the parity bit
// STOP    | sampling stop bits, then publishing the frame
module uart_recv
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  bps_mode,
  input  logic [3:0]  data_num,
  input  logic [1:0]  check_mode,
  input  logic [1:0]  stop_num,
  input  logic        uart_rxd,
  input  logic        rx_ack,
  output logic        rx_valid,
  output logic [15:0] rx_data,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overrun,
  output logic        rx_busy
);

  logic         rxd_meta;
  logic         rxd_sync;
  logic [1:0]   sync_fill;
  logic         armed;
  uart_state_t  state;
  logic [3:0]   bit_cnt;
  logic [3:0]   data_num_q;
  logic [1:0]   stop_num_q;
  parity_mode_t check_mode_q;
  logic [15:0]  shreg;
  logic         par_acc;
  logic         perr_acc;
  logic         ferr_acc;
  logic         tick;
  logic         start_edge;
  logic         ack_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd_meta  <= 1'b1;
      rxd_sync  <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      rxd_meta  <= uart_rxd;
      rxd_sync  <= rxd_meta;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // Arming needs a genuine high sample, so a line held low through reset or
  // after a broken stop bit cannot fake a start edge.
  assign start_edge = (state == S_IDLE) && armed && !rxd_sync;
  assign ack_ok     = rx_ack && rx_valid;

  uart_baud_div #(
    .CLK_FREQ(CLK_FREQ)
  ) u_baud_div (
    .clk      (clk),
    .rstn     (rstn),
    .restart  (start_edge),
    .bps_mode (bps_mode),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      armed        <= 1'b0;
      bit_cnt      <= '0;
      data_num_q   <= '0;
      stop_num_q   <= '0;
      check_mode_q <= PAR_NONE;
      shreg        <= '0;
      par_acc      <= 1'b0;
      perr_acc     <= 1'b0;
      ferr_acc     <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      if (ack_ok) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (sync_fill[1] && rxd_sync) armed <= 1'b1;
          if (start_edge) begin
            state        <= S_START;
            armed        <= 1'b0;
            rx_busy      <= 1'b1;
            data_num_q   <= data_num;
            stop_num_q   <= stop_num;
            check_mode_q <= parity_mode_t'(check_mode);
          end
        end
        S_START: begin
          if (tick) begin
            if (!rxd_sync) begin
              state    <= S_DATA;
              bit_cnt  <= '0;
              shreg    <= '0;
              par_acc  <= 1'b0;
              perr_acc <= 1'b0;
              ferr_acc <= 1'b0;
            end else begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            shreg   <= {shreg[14:0], rxd_sync};
            par_acc <= par_acc ^ rxd_sync;
            if (bit_cnt == data_num_q) begin
              bit_cnt <= '0;
              state   <= (check_mode_q == PAR_ODD || check_mode_q == PAR_EVEN) ? S_CHECK : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_CHECK: begin
          if (tick) begin
            perr_acc <= (check_mode_q == PAR_ODD) ? !(par_acc ^ rxd_sync) : (par_acc ^ rxd_sync);
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (!rxd_sync) ferr_acc <= 1'b1;
            if (bit_cnt == {2'b00, stop_num_q}) begin
              state      <= S_IDLE;
              rx_busy    <= 1'b0;
              rx_data    <= shreg;
              parity_err <= perr_acc;
              frame_err  <= ferr_acc | !rxd_sync;
              rx_valid   <= 1'b1;
              overrun    <= rx_valid && !rx_ack;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_recv.sv
// Randomized and directed bench for uart_recv: frames are built from the
// serial format rules, expected words go into a queue checked by a monitor.
module tb_uart_recv;

  localparam int CLK_FREQ = 50000000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  bps_mode = '0;
  logic [3:0]  data_num = '0;
  logic [1:0]  check_mode = '0;
  logic [1:0]  stop_num = '0;
  logic        uart_rxd = 1'b0;
  logic        rx_ack;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        parity_err;
  logic        frame_err;
  logic        overrun;
  logic        rx_busy;

  logic mon_ack = 1'b0;
  logic man_ack = 1'b0;
  bit   mon_en = 1'b0;
  assign rx_ack = mon_ack | man_ack;

  uart_recv #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bps_mode   (bps_mode),
    .data_num   (data_num),
    .check_mode (check_mode),
    .stop_num   (stop_num),
    .uart_rxd   (uart_rxd),
    .rx_ack     (rx_ack),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        perr;
    logic        ferr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   bauds [8] = '{9600, 19200, 38400, 115200, 230400, 460800, 921600, 9600};

  function automatic int period_of(input int m);
    return CLK_FREQ / bauds[m];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input int m, input int nbits, input int data, input int cm,
                            input int sn, input bit pflip, input int stopmask,
                            input bit scramble, input bit push, input bit idle_lvl);
    int   p;
    int   d;
    int   ones;
    bit   par_en;
    bit   pbit;
    exp_t e;
    p      = period_of(m);
    d      = data & ((1 << nbits) - 1);
    ones   = $countones(d);
    par_en = (cm == 1) || (cm == 2);
    // parity bit making the total count of ones odd (odd mode) or even (even mode)
    pbit   = (cm == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    pbit   = pbit ^ pflip;
    e.data = 16'(d);
    e.perr = par_en && (((ones + int'(pbit)) % 2) != ((cm == 1) ? 1 : 0));
    e.ferr = (stopmask & ((1 << (sn + 1)) - 1)) != 0;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    bps_mode   = 3'(m);
    data_num   = 4'(nbits - 1);
    check_mode = 2'(cm);
    stop_num   = 2'(sn);
    @(negedge clk);
    uart_rxd = 1'b0;
    if (scramble) begin
      repeat (5) @(negedge clk);
      bps_mode   = 3'($urandom);
      data_num   = 4'($urandom);
      check_mode = 2'($urandom);
      stop_num   = 2'($urandom);
      repeat (p - 5) @(negedge clk);
    end else begin
      repeat (p) @(negedge clk);
    end
    for (int i = nbits - 1; i >= 0; i--) begin
      uart_rxd = d[i];
      repeat (p) @(negedge clk);
    end
    if (par_en) begin
      uart_rxd = pbit;
      repeat (p) @(negedge clk);
    end
    for (int s = 0; s <= sn; s++) begin
      uart_rxd = !stopmask[s];
      repeat (p) @(negedge clk);
    end
    uart_rxd = idle_lvl;
  endtask

  task automatic wait_for_busy(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rx_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(input int limit);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk("all_frames_received", exp_q.size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && rx_valid && !mon_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: rx_data 0x%0h arrived with nothing expected", rx_data);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", int'(rx_data), int'(e.data));
          chk("parity_err", int'(parity_err), int'(e.perr));
          chk("frame_err", int'(frame_err), int'(e.ferr));
          chk("overrun", int'(overrun), 0);
        end
        mon_ack = 1'b1;
        @(negedge clk);
        mon_ack = 1'b0;
      end
    end
  end

  initial begin : stimulus
    bit ok;
    bit seen_busy;
    int cnt;
    int p;
    int h;
    int nb;
    int cm;
    int sn;

    // reset with the line held low, then release while it is still low
    repeat (5) @(negedge clk);
    chk("reset_valid", int'(rx_valid), 0);
    chk("reset_data", int'(rx_data), 0);
    chk("reset_flags", int'({parity_err, frame_err, overrun}), 0);
    chk("reset_busy", int'(rx_busy), 0);
    rstn = 1'b1;
    repeat (600) @(negedge clk);
    chk("low_after_reset_no_start", int'(rx_busy), 0);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk);

    // 115200 8N1 0xA5 with start-to-valid latency check
    mon_en = 1'b1;
    p = period_of(3);
    h = p / 2;
    fork
      send_frame(3, 8, 'hA5, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
      begin
        wait_for_busy(2000, ok);
        chk("a5_busy_seen", int'(ok), 1);
        cnt = 0;
        while (!rx_valid && cnt < 20000) begin
          @(negedge clk);
          cnt++;
        end
        chk("a5_valid_latency", cnt, h + 9 * p);
      end
    join
    drain(2000);

    // 100-cycle glitch at 115200
    @(negedge clk);
    bps_mode = 3'd3;
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (50) @(negedge clk);
    chk("glitch_busy_rises", int'(rx_busy), 1);
    repeat (50) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_busy_clears", int'(rx_busy), 0);
    chk("glitch_no_valid", int'(rx_valid), 0);

    // 16-bit odd parity, good and flipped parity bit
    send_frame(5, 16, 'h8001, 1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    drain(2000);
    send_frame(5, 16, 'h8001, 1, 0, 1'b1, 0, 1'b0, 1'b1, 1'b1);
    drain(2000);

    // second of two stop bits low, line stays low afterwards
    p = period_of(5);
    send_frame(5, 8, 'h96, 0, 1, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    seen_busy = 1'b0;
    for (int i = 0; i < 4 * p; i++) begin
      @(negedge clk);
      if (i > p && rx_busy) seen_busy = 1'b1;
    end
    chk("no_start_while_low", int'(seen_busy), 0);
    drain(100);
    uart_rxd = 1'b1;
    repeat (2 * p) @(negedge clk);
    send_frame(5, 8, 'h5E, 2, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    drain(2000);

    // random frames, config scrambled mid-frame
    for (int f = 0; f < 16; f++) begin
      nb = $urandom_range(1, 16);
      cm = $urandom_range(0, 3);
      sn = $urandom_range(0, 3);
      send_frame($urandom_range(4, 6), nb, int'($urandom & 32'hFFFF), cm, sn,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0) ? (1 << $urandom_range(0, sn)) : 0,
                 1'b1, 1'b1, 1'b1);
      repeat ($urandom_range(1, 50)) @(negedge clk);
    end
    drain(5000);

    // overrun: two frames without acknowledge
    mon_en = 1'b0;
    p = period_of(5);
    h = p / 2;
    send_frame(5, 8, 'h11, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    send_frame(5, 8, 'h22, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("ovr_valid", int'(rx_valid), 1);
    chk("ovr_data", int'(rx_data), 'h22);
    chk("ovr_flag", int'(overrun), 1);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    chk("ovr_ack_valid", int'(rx_valid), 0);
    chk("ovr_ack_flag", int'(overrun), 0);

    // completion in the same cycle as an acknowledge
    send_frame(5, 8, 'h33, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    fork
      send_frame(5, 8, 'h44, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
      begin
        wait_for_busy(2000, ok);
        chk("coin_busy_seen", int'(ok), 1);
        repeat (h + 9 * p - 1) @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        chk("coin_valid", int'(rx_valid), 1);
        chk("coin_data", int'(rx_data), 'h44);
        chk("coin_overrun", int'(overrun), 0);
      end
    join

    // reset asserted in the middle of the data bits
    fork
      send_frame(5, 8, 'h5A, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
      begin
        wait_for_busy(2000, ok);
        repeat (3 * p) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_data", int'(rx_data), 0);
        chk("rst_flags", int'({parity_err, frame_err, overrun}), 0);
        chk("rst_busy", int'(rx_busy), 0);
      end
    join
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    repeat (2 * p) @(negedge clk);
    chk("rst_idle_after", int'(rx_busy), 0);
    mon_en = 1'b1;
    send_frame(5, 8, 'h3C, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    drain(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
